// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: compare codes and the
// 2-bit predictor counter encodings.
package branch_pkg;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLT  = 3'b100;
   localparam logic [2:0] BR_BGE  = 3'b101;
   localparam logic [2:0] BR_BLTU = 3'b110;
   localparam logic [2:0] BR_BGEU = 3'b111;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic up);
      logic [1:0] nxt;
      nxt = cnt;
      if (up && cnt != CNT_ST)
         nxt = cnt + 2'd1;
      else if (!up && cnt != CNT_SNT)
         nxt = cnt - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one registered update port (no bypass).
module bht
   import branch_pkg::*;
#(
   parameter int         DEPTH    = 64,
   parameter logic [1:0] CNT_INIT = CNT_WNT,
   parameter int         IDX_W    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   logic [1:0] cnt_q [DEPTH];
   logic [1:0] upd_cnt_d;

   assign rd_taken_o = cnt_q[rd_idx_i][1];
   assign upd_cnt_d  = cnt_step(cnt_q[upd_idx_i], upd_taken_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            cnt_q[i] <= CNT_INIT;
      end else if (upd_en_i) begin
         cnt_q[upd_idx_i] <= upd_cnt_d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches in one cycle, trains the predictor table
// and keeps branch / mispredict performance counters.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         BHT_DEPTH = 64,
   parameter logic [1:0] CNT_INIT  = CNT_WNT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      b_control,
   input  logic [XLEN-1:0] r1,
   input  logic [XLEN-1:0] r2,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic            pred_taken,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            taken,
   output logic [XLEN-1:0] target,
   output logic            mispredict,
   output logic            illegal,
   input  logic [XLEN-1:0] query_pc,
   output logic            query_taken,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts,
   input  logic            perf_clear
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic            accept;
   logic            taken_c, illegal_c, mis_c;
   logic [XLEN-1:0] target_c;

   logic            out_valid_q, out_valid_d;
   logic            taken_q, taken_d;
   logic            mis_q, mis_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] target_q, target_d;
   logic [31:0]     perf_br_q, perf_br_d;
   logic [31:0]     perf_mp_q, perf_mp_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      taken_c   = 1'b0;
      illegal_c = 1'b0;
      case (b_control)
         BR_BEQ:  taken_c = (r1 == r2);
         BR_BNE:  taken_c = (r1 != r2);
         BR_BLT:  taken_c = ($signed(r1) <  $signed(r2));
         BR_BGE:  taken_c = ($signed(r1) >= $signed(r2));
         BR_BLTU: taken_c = (r1 <  r2);
         BR_BGEU: taken_c = (r1 >= r2);
         default: illegal_c = 1'b1;
      endcase
   end

   assign target_c = taken_c ? (pc + imm) : (pc + XLEN'(4));
   assign mis_c    = (taken_c != pred_taken) && !illegal_c;

   always_comb begin
      out_valid_d = out_valid_q;
      taken_d     = taken_q;
      mis_d       = mis_q;
      illegal_d   = illegal_q;
      target_d    = target_q;
      if (accept) begin
         out_valid_d = 1'b1;
         taken_d     = taken_c;
         mis_d       = mis_c;
         illegal_d   = illegal_c;
         target_d    = target_c;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Clear wins over a same-cycle increment; counts stick at all-ones.
   always_comb begin
      perf_br_d = perf_br_q;
      perf_mp_d = perf_mp_q;
      if (perf_clear) begin
         perf_br_d = '0;
         perf_mp_d = '0;
      end else if (accept && !illegal_c) begin
         if (perf_br_q != '1)
            perf_br_d = perf_br_q + 32'd1;
         if (mis_c && perf_mp_q != '1)
            perf_mp_d = perf_mp_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         mis_q       <= 1'b0;
         illegal_q   <= 1'b0;
         target_q    <= '0;
         perf_br_q   <= '0;
         perf_mp_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         taken_q     <= taken_d;
         mis_q       <= mis_d;
         illegal_q   <= illegal_d;
         target_q    <= target_d;
         perf_br_q   <= perf_br_d;
         perf_mp_q   <= perf_mp_d;
      end
   end

   bht #(
      .DEPTH    (BHT_DEPTH),
      .CNT_INIT (CNT_INIT),
      .IDX_W    (IDX_W)
   ) u_bht (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_idx_i    (query_pc[IDX_W+1:2]),
      .rd_taken_o  (query_taken),
      .upd_en_i    (accept && !illegal_c),
      .upd_idx_i   (pc[IDX_W+1:2]),
      .upd_taken_i (taken_c)
   );

   assign out_valid        = out_valid_q;
   assign taken            = taken_q;
   assign mispredict       = mis_q;
   assign illegal          = illegal_q;
   assign target           = target_q;
   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mp_q;

endmodule
